// File: rtl/count_trace_if.sv
// Read-side handshake of the count trace buffer: head entry valid/ready and data.
// RD_W must match the buffer's entry width (DATA_W, or DATA_W+TS_W with timestamps).
interface count_trace_if #(
    parameter int RD_W = 4
);
    logic            rd_valid;
    logic            rd_ready;
    logic [RD_W-1:0] rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/count_trace_buffer.sv
// Trace FIFO that records each new counter value during a counting run.
// Optional feature macro: COUNT_TRACE_TIMESTAMP_EN adds a per-entry run timestamp.
module count_trace_buffer #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int TS_W   = 8,
    parameter int DROP_W = 4
) (
    input  logic                       clkin,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          cnt_in,
    input  logic                       active_in,
    input  logic                       done_in,
    input  logic                       clear,
    count_trace_if.master              rd,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic [DROP_W-1:0]          drop_cnt,
    output logic                       run_done
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);
`ifdef COUNT_TRACE_TIMESTAMP_EN
    localparam int RD_W = DATA_W + TS_W;
`else
    localparam int RD_W = DATA_W;
`endif

    typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                overflow_q, overflow_d;
    logic [DROP_W-1:0]   drop_q, drop_d;
    logic                run_done_q, run_done_d;
    logic [RD_W-1:0]     mem [DEPTH];

    logic                flush, push_req, pop, full, wr_en, drop, not_empty;
    logic [RD_W-1:0]     wr_entry;
`ifdef COUNT_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]     ts_q, ts_d;
`endif

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        run_done_d = run_done_q;
        push_req   = 1'b0;
`ifdef COUNT_TRACE_TIMESTAMP_EN
        ts_d       = ts_q;
`endif
        case (state_q)
            IDLE: begin
                prev_d = cnt_in;
                if (active_in) begin
                    // first sample of a run is always stored, even if equal to prev
                    state_d  = ARMED;
                    push_req = 1'b1;
`ifdef COUNT_TRACE_TIMESTAMP_EN
                    ts_d     = '0;
`endif
                end
            end
            ARMED: begin
                prev_d = cnt_in;
`ifdef COUNT_TRACE_TIMESTAMP_EN
                ts_d   = ts_q + TS_W'(1);
`endif
                if (done_in) begin
                    state_d    = DONE;
                    run_done_d = 1'b1;
                    push_req   = (cnt_in != prev_q);
                end else if (!active_in) begin
                    state_d = IDLE;
                end else begin
                    push_req = (cnt_in != prev_q);
                end
            end
            default: ;
        endcase

        flush      = rst | clear;
        not_empty  = (level_q != '0);
        full       = (level_q == LVL_W'(DEPTH));
        pop        = not_empty & rd.rd_ready & ~flush;
        // a full FIFO still accepts a push when the head leaves in the same cycle
        wr_en      = push_req & (~full | pop) & ~flush;
        drop       = push_req & full & ~pop;
        wr_ptr_d   = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        level_d    = level_q + LVL_W'(wr_en) - LVL_W'(pop);
        overflow_d = overflow_q | drop;
        drop_d     = drop ? sat_inc(drop_q) : drop_q;
`ifdef COUNT_TRACE_TIMESTAMP_EN
        wr_entry   = {ts_d, cnt_in};
`else
        wr_entry   = cnt_in;
`endif
    end

    always_ff @(posedge clkin) begin
        if (flush) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            run_done_q <= 1'b0;
`ifdef COUNT_TRACE_TIMESTAMP_EN
            ts_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            run_done_q <= run_done_d;
`ifdef COUNT_TRACE_TIMESTAMP_EN
            ts_q       <= ts_d;
`endif
        end
    end

    // storage is data only; writes are suppressed by flush through wr_en
    always_ff @(posedge clkin) begin
        if (wr_en) mem[wr_ptr_q] <= wr_entry;
    end

    assign rd.rd_valid = not_empty;
    assign rd.rd_data  = not_empty ? mem[rd_ptr_q] : '0;
    assign level       = level_q;
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_q;
    assign run_done    = run_done_q;
endmodule

// File: tb/tb_count_trace_buffer.sv
// Directed bench for count_trace_buffer: reset, dedup, overflow, full push+pop,
// done handling, saturation and clear.
module tb_count_trace_buffer;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 8;
    localparam int TS_W   = 8;
    localparam int DROP_W = 4;
`ifdef COUNT_TRACE_TIMESTAMP_EN
    localparam int RD_W = DATA_W + TS_W;
`else
    localparam int RD_W = DATA_W;
`endif

    logic              clkin = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] cnt_in;
    logic              active_in;
    logic              done_in;
    logic              clear;
    logic [3:0]        level;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;
    logic              run_done;
    logic [DATA_W-1:0] head_val;

    int n_chk  = 0;
    int n_fail = 0;
    int drain_exp [8] = '{2, 3, 4, 5, 6, 7, 8, 11};

    count_trace_if #(.RD_W(RD_W)) rd_if ();

    count_trace_buffer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(DROP_W)
    ) dut (
        .clkin(clkin), .rst(rst), .cnt_in(cnt_in), .active_in(active_in),
        .done_in(done_in), .clear(clear), .rd(rd_if), .level(level),
        .overflow(overflow), .drop_cnt(drop_cnt), .run_done(run_done)
    );

    always #5 clkin = ~clkin;

    assign head_val = rd_if.rd_data[DATA_W-1:0];

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; cnt_in = '0; active_in = 1'b0; done_in = 1'b0;
        rd_if.rd_ready = 1'b0;

        // 1: reset held two cycles with inputs toggling
        cnt_in = 4'd5; active_in = 1'b1; done_in = 1'b1; clear = 1'b1; rd_if.rd_ready = 1'b1;
        tick();
        cnt_in = 4'd10; active_in = 1'b1; done_in = 1'b0; clear = 1'b0; rd_if.rd_ready = 1'b0;
        tick();
        chk("rst_level", level, 0);
        chk("rst_valid", rd_if.rd_valid, 0);
        chk("rst_data", rd_if.rd_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_run_done", run_done, 0);
        rst = 1'b0; active_in = 1'b0; cnt_in = '0;
        tick();
        chk("post_rst_level", level, 0);

        // 2: 3,3,5,7 -> entries 3,5,7
        active_in = 1'b1;
        cnt_in = 4'd3; tick();
        chk("first_push_valid", rd_if.rd_valid, 1);
        chk("first_push_level", level, 1);
        cnt_in = 4'd3; tick();
        cnt_in = 4'd5; tick();
        cnt_in = 4'd7; tick();
        chk("dedup_level", level, 3);
        chk("dedup_head0", head_val, 3);
`ifdef COUNT_TRACE_TIMESTAMP_EN
        chk("ts_head0", rd_if.rd_data[RD_W-1:DATA_W], 0);
`endif
        rd_if.rd_ready = 1'b1; tick();
        chk("dedup_head1", head_val, 5);
        chk("dedup_level1", level, 2);
`ifdef COUNT_TRACE_TIMESTAMP_EN
        chk("ts_head1", rd_if.rd_data[RD_W-1:DATA_W], 2);
`endif
        tick();
        chk("dedup_head2", head_val, 7);
`ifdef COUNT_TRACE_TIMESTAMP_EN
        chk("ts_head2", rd_if.rd_data[RD_W-1:DATA_W], 3);
`endif
        tick();
        chk("drained_valid", rd_if.rd_valid, 0);
        chk("drained_level", level, 0);
        rd_if.rd_ready = 1'b0;

        // 3: ten distinct values into eight entries
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cnt_in = 4'(i + 1);
            tick();
        end
        chk("full_level", level, 8);
        chk("full_overflow", overflow, 1);
        chk("full_drop", drop_cnt, 2);

        // 4: push and pop on a full FIFO
        cnt_in = 4'd11; rd_if.rd_ready = 1'b1; tick();
        chk("full_pushpop_level", level, 8);
        chk("full_pushpop_drop", drop_cnt, 2);
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", head_val, 32'(drain_exp[i]));
            tick();
        end
        chk("drain_empty", level, 0);
        rd_if.rd_ready = 1'b0;

        // drop counter saturation
        for (int i = 0; i < 30; i++) begin
            cnt_in = 4'(i);
            tick();
        end
        chk("sat_drop", drop_cnt, 15);
        chk("sat_level", level, 8);

        // pop on empty is ignored
        clear = 1'b1; active_in = 1'b0; tick(); clear = 1'b0;
        rd_if.rd_ready = 1'b1; tick();
        chk("empty_pop_level", level, 0);
        chk("empty_pop_valid", rd_if.rd_valid, 0);
        rd_if.rd_ready = 1'b0;

        // ARMED -> IDLE stores nothing; re-arming stores first sample again
        active_in = 1'b1; cnt_in = 4'd6; tick();
        active_in = 1'b0; tick();
        chk("disarm_level", level, 1);
        active_in = 1'b1; tick();
        chk("rearm_level", level, 2);

        // 5: done with changed value, then frozen
        clear = 1'b1; tick(); clear = 1'b0;
        cnt_in = 4'd4; tick();
        tick();
        done_in = 1'b1; cnt_in = 4'd9; tick();
        chk("done_run_done", run_done, 1);
        chk("done_level", level, 2);
        done_in = 1'b0;
        cnt_in = 4'd1; tick();
        cnt_in = 4'd2; active_in = 1'b0; tick();
        active_in = 1'b1; cnt_in = 4'd3; tick();
        chk("done_frozen_level", level, 2);
        rd_if.rd_ready = 1'b1;
        chk("done_head0", head_val, 4);
        tick();
        chk("done_head1", head_val, 9);
        tick();
        chk("done_drained", level, 0);
        chk("done_sticky", run_done, 1);
        rd_if.rd_ready = 1'b0;

        // 6: clear mid-run with level 5, overflow set and a pop pending
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clear_run_done", run_done, 0);
        for (int i = 0; i < 10; i++) begin
            cnt_in = 4'(i + 1);
            tick();
        end
        rd_if.rd_ready = 1'b1;
        tick(); tick(); tick();
        chk("pre_clear_level", level, 5);
        clear = 1'b1; cnt_in = 4'd12; tick(); clear = 1'b0;
        chk("clear_level", level, 0);
        chk("clear_valid", rd_if.rd_valid, 0);
        chk("clear_overflow", overflow, 0);
        chk("clear_drop", drop_cnt, 0);
        rd_if.rd_ready = 1'b0; cnt_in = 4'd0; tick();
        chk("clear_idle_push", level, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
